// File: rtl/cache_fill_arbiter.sv
// Arbitrates the shared main memory between I-cache and D-cache: block fills on
// misses (round-robin when both miss) and single-word write-through stores.
module cache_fill_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               icache_miss,
  input  logic [15:0]                        icache_miss_addr,
  input  logic                               dcache_miss,
  input  logic [15:0]                        dcache_miss_addr,
  input  logic                               dcache_wr,
  input  logic [15:0]                        dcache_wr_addr,
  input  logic [15:0]                        dcache_wr_data,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [15:0]                        mem_addr,
  output logic [15:0]                        mem_data_out,
  input  logic                               mem_data_valid,
  input  logic [15:0]                        mem_data_in,
  output logic [15:0]                        fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               fill_we_i,
  output logic                               fill_we_d,
  output logic                               fill_done_i,
  output logic                               fill_done_d,
  output logic                               icache_stall,
  output logic                               dcache_stall
);
  localparam int unsigned WW = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CW = WW + 1;
  localparam logic [CW-1:0] FULL = CW'(WORDS_PER_BLOCK);
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  state_t         state;
  grant_t         granted, last_grant;
  logic [CW-1:0]  issue, rcv;
  logic [15:WW+1] base;
  logic           pick_d, issuing, receiving, last_word;

  // Word-offset address bits are regenerated by the issue counter, and memory
  // latency is absorbed by counting returned words rather than timing them.
  logic unused_cfg;
  assign unused_cfg = ^{icache_miss_addr[WW:0], dcache_miss_addr[WW:0], (MEM_LATENCY != 0)};

  assign pick_d    = dcache_miss & (~icache_miss | (last_grant == GNT_I));
  assign issuing   = (state == FILL) && (issue != FULL);
  assign receiving = (state == FILL) && mem_data_valid;
  assign last_word = receiving && (rcv == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      granted    <= GNT_I;
      last_grant <= GNT_I;
      issue      <= '0;
      rcv        <= '0;
      base       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dcache_wr) begin
            state <= WRITE;
          end else if (icache_miss || dcache_miss) begin
            state      <= FILL;
            granted    <= pick_d ? GNT_D : GNT_I;
            last_grant <= pick_d ? GNT_D : GNT_I;
            base       <= pick_d ? dcache_miss_addr[15:WW+1] : icache_miss_addr[15:WW+1];
          end
        end
        WRITE: state <= IDLE;
        FILL: begin
          if (issue != FULL) issue <= issue + 1'b1;
          if (last_word) begin
            state <= IDLE;
            issue <= '0;
            rcv   <= '0;
          end else if (receiving) begin
            rcv <= rcv + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    if (state == WRITE) begin
      mem_en       = 1'b1;
      mem_wr       = 1'b1;
      mem_addr     = dcache_wr_addr;
      mem_data_out = dcache_wr_data;
    end else if (issuing) begin
      mem_en   = 1'b1;
      mem_addr = {base, issue[WW-1:0], 1'b0};
    end
  end

  always_comb begin
    fill_data   = '0;
    fill_word   = '0;
    if (receiving) begin
      fill_data = mem_data_in;
      fill_word = rcv[WW-1:0];
    end
    fill_we_i   = receiving && (granted == GNT_I);
    fill_we_d   = receiving && (granted == GNT_D);
    fill_done_i = last_word && (granted == GNT_I);
    fill_done_d = last_word && (granted == GNT_D);
  end

  // Stalls are held low while reset is asserted even if requests are pending.
  assign icache_stall = rst & icache_miss & ~fill_done_i;
  assign dcache_stall = rst & ((dcache_miss & ~fill_done_d) | (dcache_wr & (state != WRITE)));

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency memory model.
module tb_cache_fill_arbiter;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        icache_miss = 1'b0, dcache_miss = 1'b0, dcache_wr = 1'b0;
  logic [15:0] icache_miss_addr = '0, dcache_miss_addr = '0;
  logic [15:0] dcache_wr_addr = '0, dcache_wr_data = '0;
  logic        mem_en, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_data_out, mem_data_in, fill_data;
  logic [2:0]  fill_word;
  logic        fill_we_i, fill_we_d, fill_done_i, fill_done_d;
  logic        icache_stall, dcache_stall;
  logic [15:0] rd_base = 16'hA000;
  logic [16:0] pipe [LAT];

  int n_total = 0;
  int n_bad   = 0;

  cache_fill_arbiter #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .fill_data(fill_data), .fill_word(fill_word),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .fill_done_i(fill_done_i), .fill_done_d(fill_done_d),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall)
  );

  always #5 clk = ~clk;

  // Memory: a read issued in cycle n returns rd_base + word index in cycle n+LAT.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {mem_en & ~mem_wr, mem_addr};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mem_data_valid = pipe[LAT-1][16];
  assign mem_data_in    = rd_base + {13'd0, pipe[LAT-1][3:1]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the grant cycle (cycle 0); returns in cycle 13 with the miss dropped.
  task automatic run_fill(input bit is_d, input logic [15:0] addr, input logic [15:0] dbase,
                          input int wr_at);
    logic [15:0] exp_addr;
    rd_base = dbase;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) step();
      if (c == wr_at) dcache_wr = 1'b1;
      #3;
      check("mem_en", mem_en, (c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) begin
        exp_addr = (addr & 16'hFFF0) | 16'((c - 1) * 2);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wr_rd", mem_wr, 0);
      end
      check("fill_we_g", is_d ? fill_we_d : fill_we_i, (c >= 5));
      check("fill_we_o", is_d ? fill_we_i : fill_we_d, 0);
      if (c >= 5) begin
        check("fill_word", fill_word, c - 5);
        check("fill_data", fill_data, dbase + 16'(c - 5));
      end
      check("fill_done", is_d ? fill_done_d : fill_done_i, (c == 12));
      check("stall_g", is_d ? dcache_stall : icache_stall, (c != 12));
      if (wr_at >= 0 && c >= wr_at) begin
        check("wr_stall", dcache_stall, 1);
        check("wr_held", mem_wr, 0);
      end
    end
    step();
    if (is_d) dcache_miss = 1'b0; else icache_miss = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with both misses pending
    icache_miss = 1'b1; icache_miss_addr = 16'h1236;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h2458;
    step(); step();
    #3;
    check("rst_mem_en", mem_en, 0);
    check("rst_istall", icache_stall, 0);
    check("rst_dstall", dcache_stall, 0);
    check("rst_we", {fill_we_i, fill_we_d, fill_done_i, fill_done_d}, 0);
    step();
    rst = 1'b1;
    // last_grant=I after reset: D first, then I at cycle 13
    run_fill(1'b1, 16'h2458, 16'hD000, -1);
    run_fill(1'b0, 16'h1236, 16'hA000, -1);
    // Lone D miss leaves last_grant=D; then both -> I first
    dcache_miss = 1'b1; dcache_miss_addr = 16'h3300;
    run_fill(1'b1, 16'h3300, 16'hD100, -1);
    icache_miss = 1'b1; icache_miss_addr = 16'h4010;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h50F2;
    run_fill(1'b0, 16'h4010, 16'hA100, -1);
    run_fill(1'b1, 16'h50F2, 16'hD200, -1);

    // Store concurrent with I-miss: store first, fill starts two cycles later
    dcache_wr = 1'b1; dcache_wr_addr = 16'h0040; dcache_wr_data = 16'hBEEF;
    icache_miss = 1'b1; icache_miss_addr = 16'h6000;
    #3;
    check("st_stall0", dcache_stall, 1);
    check("st_en0", mem_en, 0);
    step(); #3;
    check("st_en1", mem_en, 1);
    check("st_wr1", mem_wr, 1);
    check("st_addr1", mem_addr, 16'h0040);
    check("st_data1", mem_data_out, 16'hBEEF);
    check("st_stall1", dcache_stall, 0);
    step();
    dcache_wr = 1'b0;
    run_fill(1'b0, 16'h6000, 16'hA200, -1);

    // Store raised mid-fill waits for the fill, then goes out
    icache_miss = 1'b1; icache_miss_addr = 16'h7A0E;
    dcache_wr_addr = 16'h0102; dcache_wr_data = 16'h1357;
    run_fill(1'b0, 16'h7A0E, 16'hA300, 4);
    #3;
    check("mw_stall13", dcache_stall, 1);
    check("mw_en13", mem_en, 0);
    step(); #3;
    check("mw_wr14", mem_wr, 1);
    check("mw_addr14", mem_addr, 16'h0102);
    check("mw_data14", mem_data_out, 16'h1357);
    step();
    dcache_wr = 1'b0;

    // Reset in cycle 6 of a D fill aborts it; a fresh miss restarts at word 0
    dcache_miss = 1'b1; dcache_miss_addr = 16'h8888;
    rd_base = 16'hD300;
    for (int c = 1; c <= 5; c++) step();
    #3;
    check("ab_we5", fill_we_d, 1);
    check("ab_word5", fill_word, 0);
    step();
    rst = 1'b0; dcache_miss = 1'b0;
    step(); #3;
    check("ab_en", mem_en, 0);
    check("ab_we", fill_we_d, 0);
    check("ab_done", fill_done_d, 0);
    check("ab_stall", dcache_stall, 0);
    step();
    rst = 1'b1; dcache_miss = 1'b1; dcache_miss_addr = 16'h9990;
    run_fill(1'b1, 16'h9990, 16'hD400, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
